reg_issue_scoreboard: RTL

Per-register scoreboard and issue scheduler for the 8-entry, 3-bit-addressed register file of the 5-stage pipeline. It records the destination of every instruction that leaves decode, counts down the cycles until each result can be consumed (via forwarding or via register-file write-back), and decides every cycle whether the decode-stage instruction issues or stalls. It sits beside the decode stage and drives the PC/IF-ID hold and the ID-EX bubble.

---
 rtl/reg_issue_scoreboard.sv | 132 +++++++++++++
 1 files changed

// File: rtl/reg_issue_scoreboard.sv
// reg_issue_scoreboard
//
// Per-register scoreboard and issue scheduler for the small register file
// of the 5-stage pipeline. Every destination leaving decode loads two
// down-counters. raw_cnt counts cycles until the register file holds the
// result. fwd_cnt counts cycles until a forwarding path can supply it. The
// decode-stage instruction issues only when none of its sources is still
// counting on the counter that applies to it.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst              : synchronous, active-high reset
//   decode_valid     : decode holds a real instruction
//   decode_op_src1   : first source register
//   decode_op_src2   : second source register
//   decode_op_dest   : destination register (0 = no write)
//   decode_is_load   : instruction is a load
//   decode_is_branch : instruction resolves in decode, cannot use forwarding
//   forwarding_en    : forwarding paths enabled
//   flush            : squash the decode instruction this cycle
//   issue            : decode instruction moves to EX this cycle
//   pipeline_stall   : hold PC and IF/ID, bubble into ID/EX (combinational)
//   busy_mask        : bit i set while raw_cnt[i] is nonzero, bit 0 always 0
//   stall_cycles     : saturating count of stalled cycles
module reg_issue_scoreboard #(
  parameter int AW           = 3,
  parameter int LAT_WB       = 3,
  parameter int LAT_LOAD_USE = 1,
  parameter int PERF_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 decode_valid,
  input  logic [AW-1:0]        decode_op_src1,
  input  logic [AW-1:0]        decode_op_src2,
  input  logic [AW-1:0]        decode_op_dest,
  input  logic                 decode_is_load,
  input  logic                 decode_is_branch,
  input  logic                 forwarding_en,
  input  logic                 flush,
  output logic                 issue,
  output logic                 pipeline_stall,
  output logic [(2**AW)-1:0]   busy_mask,
  output logic [PERF_W-1:0]    stall_cycles
);

  localparam int NREG = 2**AW;
  localparam int CW   = $clog2(LAT_WB+1);
  localparam logic [CW-1:0] LAT_WB_C  = CW'(LAT_WB);
  localparam logic [CW-1:0] LAT_LDU_C = CW'(LAT_LOAD_USE);

  // Entry 0 is hardwired zero and has no storage.
  logic [CW-1:0] raw_cnt [1:NREG-1];
  logic [CW-1:0] fwd_cnt [1:NREG-1];

  // Read views including the constant-zero entry 0.
  logic [CW-1:0] raw_rd [NREG];
  logic [CW-1:0] fwd_rd [NREG];

  logic use_raw;
  logic src1_haz;
  logic src2_haz;
  logic live;
  logic [CW-1:0] fwd_load_val;

  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    raw_rd[0] = '0;
    fwd_rd[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      raw_rd[i] = raw_cnt[i];
      fwd_rd[i] = fwd_cnt[i];
    end
  end

  // Branches resolve in decode and cannot take a forwarded value, so they
  // (and everything when forwarding is off) wait for register write-back.
  always_comb begin
    use_raw  = decode_is_branch | ~forwarding_en;
    src1_haz = (decode_op_src1 != '0) &&
               (use_raw ? (raw_rd[decode_op_src1] != '0)
                        : (fwd_rd[decode_op_src1] != '0));
    src2_haz = (decode_op_src2 != '0) &&
               (use_raw ? (raw_rd[decode_op_src2] != '0)
                        : (fwd_rd[decode_op_src2] != '0));
    live           = decode_valid & ~flush;
    pipeline_stall = live & (src1_haz | src2_haz);
    issue          = live & ~(src1_haz | src2_haz);
    fwd_load_val   = decode_is_load ? LAT_LDU_C : '0;
  end

  always_comb begin
    busy_mask    = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_mask[i] = (raw_cnt[i] != '0);
    end
  end

  // A re-issued destination keeps the later of its pending and new
  // readiness, so an older long-latency producer is never shortened.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        raw_cnt[i] <= '0;
        fwd_cnt[i] <= '0;
      end
      stall_cycles <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue && (decode_op_dest == AW'(i))) begin
          raw_cnt[i] <= max_cnt(dec_sat(raw_cnt[i]), LAT_WB_C);
          fwd_cnt[i] <= max_cnt(dec_sat(fwd_cnt[i]), fwd_load_val);
        end else begin
          raw_cnt[i] <= dec_sat(raw_cnt[i]);
          fwd_cnt[i] <= dec_sat(fwd_cnt[i]);
        end
      end
      if (pipeline_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
